// File: rtl/ber_sync_counter.sv
// rtl/ber_sync_counter.sv - BER counter with latency search, lock monitoring and resync
module ber_sync_counter #(
    parameter int MAX_LAT    = 512,
    parameter int WIN        = 511,
    parameter int LOSS_THR   = 127,
    parameter int CNT_W      = 64,
    parameter int EARLY_LOCK = 0,
    localparam int LW        = $clog2(MAX_LAT),
    localparam int EW        = $clog2(WIN + 1)
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_rx,
    input  logic             i_ref,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [LW-1:0]    o_latency,
    output logic [EW-1:0]    o_min_errors,
    output logic [CNT_W-1:0] o_bits,
    output logic [CNT_W-1:0] o_errors,
    output logic [15:0]      o_resyncs
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state;
    logic [MAX_LAT-1:0] ref_buf;
    logic [LW-1:0]      cur_l;
    logic [LW-1:0]      best_l;
    logic [EW-1:0]      best_err;
    logic [EW-1:0]      win_cnt;
    logic [EW-1:0]      win_err;

    logic [LW-1:0]      sel_l;
    logic               err;
    logic [EW-1:0]      win_err_nxt;
    logic               win_end;
    logic               better;
    logic [EW-1:0]      cand_err;
    logic [LW-1:0]      cand_l;
    logic               last_l;

    assign o_locked = (state == LOCKED);

    // Error is taken against the buffer before this sample's reference bit is shifted in.
    always_comb begin
        sel_l       = (state == LOCKED) ? o_latency : cur_l;
        err         = ref_buf[sel_l] ^ i_rx;
        win_err_nxt = win_err + EW'(err);
        win_end     = (win_cnt == EW'(WIN - 1));
        better      = (win_err_nxt < best_err);
        cand_err    = better ? win_err_nxt : best_err;
        cand_l      = better ? cur_l : best_l;
        last_l      = (cur_l == LW'(MAX_LAT - 1));
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state        <= SEARCH;
            ref_buf      <= '0;
            cur_l        <= '0;
            best_l       <= '0;
            best_err     <= '1;
            win_cnt      <= '0;
            win_err      <= '0;
            o_latency    <= '0;
            o_min_errors <= '1;
            o_bits       <= '0;
            o_errors     <= '0;
            o_resyncs    <= '0;
        end else begin
            if (i_valid) begin
                ref_buf <= {ref_buf[MAX_LAT-2:0], i_ref};

                if (win_end) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + EW'(1);
                    win_err <= win_err_nxt;
                end

                case (state)
                    SEARCH: begin
                        if (win_end) begin
                            if (EARLY_LOCK != 0 && win_err_nxt == '0) begin
                                state        <= LOCKED;
                                o_latency    <= cur_l;
                                o_min_errors <= '0;
                                cur_l        <= '0;
                                best_err     <= '1;
                                best_l       <= '0;
                            end else if (last_l) begin
                                // Sweep done: lock on the best candidate or start over.
                                if (cand_err <= EW'(LOSS_THR)) begin
                                    state        <= LOCKED;
                                    o_latency    <= cand_l;
                                    o_min_errors <= cand_err;
                                end
                                cur_l    <= '0;
                                best_err <= '1;
                                best_l   <= '0;
                            end else begin
                                cur_l    <= cur_l + LW'(1);
                                best_err <= cand_err;
                                best_l   <= cand_l;
                            end
                        end
                    end
                    LOCKED: begin
                        if (o_bits != '1) begin
                            o_bits <= o_bits + CNT_W'(1);
                        end
                        if (err && o_errors != '1) begin
                            o_errors <= o_errors + CNT_W'(1);
                        end
                        if (win_end && win_err_nxt > EW'(LOSS_THR)) begin
                            state    <= SEARCH;
                            cur_l    <= '0;
                            best_err <= '1;
                            best_l   <= '0;
                            if (o_resyncs != 16'hFFFF) begin
                                o_resyncs <= o_resyncs + 16'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end

            // Clear wins over a same-cycle count update.
            if (i_clear) begin
                o_bits   <= '0;
                o_errors <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ber_sync_counter.sv
// tb/tb_ber_sync_counter.sv - scoreboard bench for ber_sync_counter
module tb_ber_sync_counter;

    logic        clock = 1'b0;
    logic        i_reset, i_valid, i_rx, i_ref, i_clear;

    logic        m_locked, e_locked;
    logic [3:0]  m_latency, e_latency;
    logic [5:0]  m_min, e_min;
    logic [31:0] m_bits, m_errors;
    logic [7:0]  e_bits, e_errors;
    logic [15:0] m_resyncs, e_resyncs;

    always #5 clock = ~clock;

    ber_sync_counter #(
        .MAX_LAT(16), .WIN(32), .LOSS_THR(8), .CNT_W(32), .EARLY_LOCK(0)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .i_rx(i_rx),
        .i_ref(i_ref), .i_clear(i_clear), .o_locked(m_locked),
        .o_latency(m_latency), .o_min_errors(m_min), .o_bits(m_bits),
        .o_errors(m_errors), .o_resyncs(m_resyncs)
    );

    ber_sync_counter #(
        .MAX_LAT(16), .WIN(32), .LOSS_THR(8), .CNT_W(8), .EARLY_LOCK(1)
    ) dut_early (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .i_rx(i_rx),
        .i_ref(i_ref), .i_clear(i_clear), .o_locked(e_locked),
        .o_latency(e_latency), .o_min_errors(e_min), .o_bits(e_bits),
        .o_errors(e_errors), .o_resyncs(e_resyncs)
    );

    typedef struct {
        string  tag;
        int     sel;
        longint val;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad   = 0;

    bit [8:0]  prbs = 9'h1FF;
    bit [15:0] hist;
    int        delay;
    bit        flip;
    int        n_valid;
    bit        mon_on;
    int        mon_lat, mon_pos, mon_err;
    longint    bits_exp;
    int        resync_exp;
    int        lost_at = -1;

    task automatic check_val(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic longint obs(input int sel);
        case (sel)
            0:  return longint'(m_locked);
            1:  return longint'(m_latency);
            2:  return longint'(m_min);
            3:  return longint'(m_bits);
            4:  return longint'(m_errors);
            5:  return longint'(m_resyncs);
            10: return longint'(e_locked);
            11: return longint'(e_latency);
            12: return longint'(e_min);
            13: return longint'(e_bits);
            14: return longint'(e_errors);
            15: return longint'(e_resyncs);
            default: return -1;
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input longint val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_all();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, obs(e.sel), e.val);
        end
    endtask

    // One clock: build the sample, run the window model, drive, then score.
    task automatic step(input bit v, input bit clr);
        bit r, x, locked_now;
        r = 1'b0;
        x = 1'b0;
        if (v) begin
            r    = prbs[8] ^ prbs[4];
            prbs = {prbs[7:0], r};
            x    = hist[delay-1] ^ flip;
            locked_now = mon_on;
            if (clr) bits_exp = 0;
            else if (locked_now) bits_exp++;
            if (locked_now) begin
                mon_err += int'(x ^ hist[mon_lat]);
                mon_pos++;
                if (mon_pos == 32) begin
                    if (mon_err > 8) begin
                        mon_on = 1'b0;
                        resync_exp++;
                        lost_at = n_valid + 1;
                        expect_out(0, "loss_locked", 0);
                        expect_out(5, "loss_resyncs", resync_exp);
                        expect_out(3, "loss_bits", bits_exp);
                    end
                    mon_pos = 0;
                    mon_err = 0;
                end
            end
            hist = {hist[14:0], r};
            n_valid++;
        end else if (clr) begin
            bits_exp = 0;
        end
        i_valid = v;
        i_ref   = r;
        i_rx    = x;
        i_clear = clr;
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        pop_all();
    endtask

    task automatic reset_cycle(input string tag);
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_ref   = 1'($urandom_range(0, 1));
        i_rx    = 1'($urandom_range(0, 1));
        for (int d = 0; d < 2; d++) begin
            expect_out(d * 10 + 0, {tag, "_locked"}, 0);
            expect_out(d * 10 + 1, {tag, "_latency"}, 0);
            expect_out(d * 10 + 2, {tag, "_min"}, 63);
            expect_out(d * 10 + 3, {tag, "_bits"}, 0);
            expect_out(d * 10 + 4, {tag, "_errors"}, 0);
            expect_out(d * 10 + 5, {tag, "_resyncs"}, 0);
        end
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        i_valid = 1'b0;
        pop_all();
        hist = '0; delay = 5; flip = 1'b0; n_valid = 0; mon_on = 1'b0;
        mon_lat = 4; mon_pos = 0; mon_err = 0; bits_exp = 0; resync_exp = 0;
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_rx = 1'b0; i_ref = 1'b0; i_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_cycle("rst");

        // Continuous lock, clean counting, then error injection.
        for (int s = 1; s <= 2512; s++) begin
            flip = (s > 1512) && ((s - 1512) % 100 == 0);
            if (s == 159) expect_out(10, "early_pre_lock", 0);
            if (s == 160) begin
                expect_out(10, "early_lock", 1);
                expect_out(11, "early_latency", 4);
                expect_out(12, "early_min", 0);
            end
            if (s == 414) expect_out(13, "early_bits_254", 254);
            if (s == 415) expect_out(13, "early_bits_sat", 255);
            if (s == 460) expect_out(13, "early_bits_hold", 255);
            if (s == 511) expect_out(0, "pre_lock", 0);
            if (s == 512) begin
                expect_out(0, "lock", 1);
                expect_out(1, "latency", 4);
                expect_out(2, "min_errors", 0);
                expect_out(3, "bits_at_lock", 0);
            end
            if (s == 1512) begin
                expect_out(3, "bits_1000", 1000);
                expect_out(4, "errors_clean", 0);
            end
            if (s == 2512) begin
                expect_out(3, "bits_2000", 2000);
                expect_out(4, "errors_10", 10);
                expect_out(0, "still_locked", 1);
                expect_out(14, "early_errors_10", 10);
                expect_out(13, "early_bits_final", 255);
            end
            step(1'b1, 1'b0);
            if (s == 512) begin
                mon_on = 1'b1; mon_lat = 4; mon_pos = 0; mon_err = 0;
            end
        end
        flip = 1'b0;

        // Clear with a same-cycle valid sample.
        expect_out(3, "clear_bits", 0);
        expect_out(4, "clear_errors", 0);
        expect_out(1, "clear_latency", 4);
        expect_out(0, "clear_locked", 1);
        expect_out(5, "clear_resyncs", 0);
        step(1'b1, 1'b1);
        expect_out(3, "bits_after_clear", 1);
        step(1'b1, 1'b0);

        // Loss of lock and relock on the new delay.
        delay = 9;
        for (int k = 0; k < 400 && mon_on; k++) step(1'b1, 1'b0);
        check_val("loss_seen", longint'(!mon_on), 1);
        if (!mon_on) begin
            while (n_valid < lost_at + 512) begin
                if (n_valid == lost_at + 510) expect_out(0, "relock_pre", 0);
                if (n_valid == lost_at + 511) begin
                    expect_out(0, "relock", 1);
                    expect_out(1, "relock_latency", 8);
                    expect_out(2, "relock_min", 0);
                    expect_out(3, "bits_frozen", bits_exp);
                    expect_out(5, "resyncs_1", 1);
                end
                step(1'b1, 1'b0);
            end
            mon_on = 1'b1; mon_lat = 8; mon_pos = 0; mon_err = 0;
            repeat (100) step(1'b1, 1'b0);
            expect_out(10, "early_relock", 1);
            expect_out(11, "early_relock_latency", 8);
            expect_out(15, "early_resyncs", 1);
            expect_out(0, "relock_held", 1);
            step(1'b1, 1'b0);
        end

        // Gapped valid: mid-search reset, then lock at the same sample counts.
        reset_cycle("rst2");
        for (int c = 0; c < 2000 && n_valid < 300; c++) step(1'($urandom_range(0, 1)), 1'b0);
        reset_cycle("rst_mid");
        for (int c = 0; c < 4000 && n_valid < 512; c++) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            if (v) begin
                if (n_valid == 158) expect_out(10, "gap_early_pre", 0);
                if (n_valid == 159) begin
                    expect_out(10, "gap_early_lock", 1);
                    expect_out(11, "gap_early_latency", 4);
                end
                if (n_valid == 510) expect_out(0, "gap_pre_lock", 0);
                if (n_valid == 511) begin
                    expect_out(0, "gap_lock", 1);
                    expect_out(1, "gap_latency", 4);
                    expect_out(2, "gap_min", 0);
                end
            end
            step(v, 1'b0);
        end
        check_val("gap_valid_count", n_valid, 512);
        mon_on = 1'b1; mon_lat = 4; mon_pos = 0; mon_err = 0;
        expect_out(0, "gap_idle_locked", 1);
        step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        expect_out(3, "gap_bits_20", 20);
        step(1'b0, 1'b0);
        expect_out(3, "gap_clear_bits", 0);
        expect_out(1, "gap_clear_latency", 4);
        step(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ber_sync_counter.md
# ber_sync_counter

Parametrised bit-error-rate counter with automatic latency search, loss-of-lock detection and resynchronisation. It sits at the receiver output next to the PRBS reference generator. It sweeps candidate delays between the reference and received streams, locks on the best one, then accumulates saturating bit and error counts. It drops back to search when the error density in a monitoring window exceeds a threshold.

## Interface
- MAX_LAT, 512: number of candidate latencies, L = 0..MAX_LAT-1; ≥2
- WIN, 511: valid samples per evaluation window, used in search and lock monitoring; ≥1
- LOSS_THR, 127: a window error count strictly greater than this is "bad"; < WIN
- CNT_W, 64: width of the bit and error counters
- EARLY_LOCK, 0: 1 = lock immediately on a zero-error search window
- LW: derived, clog2(MAX_LAT)
- EW: derived, clog2(WIN+1)
- clock, in, 1, clock; all logic on the rising edge
- i_reset, in, 1, synchronous, active-high reset
- i_valid, in, 1, qualifies i_rx/i_ref; no state changes when low
- i_rx, in, 1, received bit
- i_ref, in, 1, reference bit
- i_clear, in, 1, synchronous clear of o_bits/o_errors only
- o_locked, out, 1, 1 in LOCKED state
- o_latency, out, LW, selected latency, valid while o_locked
- o_min_errors, out, EW, error count of the selected window
- o_bits, out, CNT_W, bits counted while locked
- o_errors, out, CNT_W, errors counted while locked
- o_resyncs, out, 16, loss-of-lock events; saturating

## Operation
- Reference buffer: MAX_LAT-bit shift register, shifted with i_ref on each valid sample; reset to all zeros. Candidate L compares i_rx against i_ref from L+1 valid samples earlier. err = buf[L] ^ i_rx, using the pre-shift buffer.
- States: SEARCH (reset state) and LOCKED.
- SEARCH:
  - Window counter counts WIN valid samples for the current L; window error accumulator win_err sums err over all WIN samples.
  - At window end: if win_err < best_err (strict), set best_err ← win_err and best_L ← L. Ties keep the lower L.
  - If EARLY_LOCK=1 and win_err==0: go to LOCKED with latency L.
  - Otherwise L++. After L = MAX_LAT-1: if best_err ≤ LOSS_THR, go to LOCKED with best_L. Else restart the sweep with L=0 and best_err=all-ones; o_locked stays 0.
- LOCKED:
  - Per valid sample: o_bits += 1, o_errors += err at o_latency.
  - Both counters saturate at 2^CNT_W−1 and hold there.
  - Monitoring window of WIN samples: at window end, if win_err > LOSS_THR, go to SEARCH with L=0, best_err reset, and o_resyncs++. Otherwise start a new window.
- o_bits/o_errors hold, not clear, through SEARCH; they are cumulative across resyncs.
- i_clear: o_bits ← 0 and o_errors ← 0. A same-cycle valid sample is discarded from these counts. Lock state, latency and o_resyncs are unaffected.
- i_reset: all state to reset values. i_reset has priority over i_clear and i_valid.

## Timing
- All outputs registered. Reset values: o_locked=0, o_latency=0, o_min_errors=all-ones, o_bits=0, o_errors=0, o_resyncs=0.
- Counter updates are visible the cycle after the qualifying valid sample.
- o_locked rises in the cycle after the last valid sample of the deciding window. It falls in the cycle after the last sample of a bad monitoring window.
- The sample that ends the deciding search window is not counted in o_bits. The first counted sample is the next valid one.
- The last sample of a bad monitoring window is still counted.
- Full sweep without early lock takes MAX_LAT×WIN valid samples.
- i_valid gaps stretch timing only; results depend only on the valid-sample sequence.
- Reset mid-search or mid-lock aborts immediately. The next cycle shows reset values.

## Test plan
- Lock, error-free: MAX_LAT=16, WIN=32, LOSS_THR=8, ref PRBS9, rx = ref delayed 5 valid samples (L=4). → o_locked=1 one cycle after valid sample 512; o_latency=4; o_min_errors=0. After 1000 more samples: o_bits=1000, o_errors=0.
- Error injection: as above, flip every 100th rx bit after lock. → After 1000 bits: o_errors=10, o_locked stays 1.
- Early lock: EARLY_LOCK=1, same stimulus. → Lock after sample 160 (5×32), o_latency=4.
- Loss and resync: after lock, change delay to 9. → o_locked falls at the end of the first bad window; o_resyncs=1; relock with o_latency=8; o_bits frozen during search.
- Gapped valid and clear: i_valid random 50% → same lock sample count as the continuous case. Pulse i_clear while locked → o_bits=0 next cycle, o_latency unchanged.
- Saturation and reset: CNT_W=8, 300 locked bits → o_bits=255. Assert i_reset mid-search → all outputs at reset values next cycle.
